mem_ctrl: RTL
=============

// Module: mem_ctrl
// PURPOSE
//  Memory-side responder for the load/store buffer and instruction-fetch queue.
//  Accepts one 32-bit-addressed request at a time, serialises it into byte
//  accesses on the single 8-bit RAM port (1-cycle read latency), assembles and
//  extends load data, and returns it with a one-cycle done pulse.
//  Sits between the LSB and IF queues and the RAM.
// PARAMETERS
//  ADDR_W     32     address width of requests and of mem_a
//  IO_REGION  2'b11  value of addr[17:16] that marks the IO region (used only with the macro)
// PORTS
//  clk          in   1       system clock
//  rst          in   1       synchronous, active-high reset
//  rollback     in   1       mispredict flush; aborts an in-flight fetch only
//  if_req       in   1       fetch request; held with if_addr until if_done
//  if_addr      in   ADDR_W  fetch address
//  if_done      out  1       1-cycle pulse; if_data valid
//  if_data      out  32      fetched word, little-endian
//  lsb_req      in   1       load/store request; held with operands until lsb_done
//  lsb_op       in   5       LB=10010 LH=10011 LW=10100 LBU=10101 LHU=10110 SB=10111 SH=11000 SW=11001
//  lsb_addr     in   ADDR_W  byte address
//  lsb_wdata    in   32      store data; low bytes used
//  lsb_rob      in   3       ROB tag, echoed back
//  lsb_done     out  1       1-cycle pulse; lsb_rdata and lsb_rob_out valid
//  lsb_rdata    out  32      extended load data; 0 for stores
//  lsb_rob_out  out  3       tag of the completed op
//  busy         out  1       high whenever state != IDLE
//  mem_din      in   8       RAM read data, valid 1 cycle after mem_a
//  mem_dout     out  8       RAM write data
//  mem_a        out  ADDR_W  RAM byte address
//  mem_wr       out  1       1 = write, 0 = read
// BEHAVIOUR
//  Interface contract: one clock (clk); rst is synchronous and active-high.
//  Reset: state = IDLE, all outputs = 0, round-robin pointer = LSB.
//    Reset mid-operation aborts the operation; no done pulse is issued.
//  States: IDLE, READ, WRITE. Requests are accepted only in IDLE.
//    Both request inputs are level-held until their done pulse.
//  Arbitration (IDLE, both pending): LSB wins unless the last served was LSB.
//    In that case IF wins (strict alternation, no starvation).
//    A single pending request always wins.
//  Byte count N: LB/LBU/SB=1, LH/LHU/SH=2, LW/SW/fetch=4.
//    lsb_op not in the table: request ignored, no done, state stays IDLE.
//  Read (cycle 0 = accept cycle):
//    cycles 1..N: mem_a = addr+i, mem_wr = 0.
//    mem_din sampled at end of cycles 2..N+1.
//    done plus data registered in cycle N+2; return to IDLE in the same cycle.
//    Next accept is possible in cycle N+2.
//  Write: cycles 1..N drive mem_a = addr+i, mem_dout = wdata[8i+7:8i], mem_wr = 1.
//    done in cycle N+1.
//  Extension: LB/LH sign-extend from bit 7/15; LBU/LHU zero-extend.
//  Address arithmetic wraps modulo 2^ADDR_W. No alignment check.
//  Idle outputs: mem_wr = 0, mem_a = 0, mem_dout = 0. Done pulses last exactly one cycle.
//  rollback while serving a fetch: state -> IDLE next cycle, if_done suppressed.
//    This holds even if rollback coincides with the done cycle.
//    rollback during an LSB op, or in IDLE, has no effect on it.
// CONFIGURATION
//  MEM_CTRL_IO_STALL_EN defined:
//    Adds input io_buffer_full (1 bit).
//    During WRITE, if io_buffer_full = 1 and addr[17:16] == IO_REGION, the controller holds:
//    mem_wr = 0, byte index frozen, done delayed by the stall length.
//  Not defined: no port; writes never stall.
// STRUCTURE
//  Shared package viola_pkg: the 5-bit opcode localparams (shared with the LSB/decoder),
//    the OP_NONE = 5'b11111 constant, and the mem_ctrl state encoding.
//  Single module; no sub-module. Byte sequencing is a 2-bit index plus a shift register.
// TESTING
//  1. RAM[0x100..0x103] = 78 56 34 12; LW @0x100.
//     -> mem_a 0x100..0x103 in cycles 1-4; lsb_done in cycle 6; rdata 0x12345678.
//  2. RAM[0x200] = 0x80; LB -> 0xFFFFFF80; LBU -> 0x00000080.
//     LH with RAM[0x201] = 0xFF -> 0xFFFFFF80.
//  3. SW 0xDEADBEEF @0x40, rob = 5.
//     -> writes EF BE AD DE, mem_wr = 1 in cycles 1-4; lsb_done in cycle 5; rob_out = 5.
//  4. if_req and lsb_req held together, back to back.
//     -> service order LSB, IF, LSB, IF; each done exactly once.
//  5. Fetch @0x0; rollback in cycle 3.
//     -> no if_done; IDLE in cycle 4; a new fetch is accepted in cycle 4.
//  6. rst during cycle 2 of SW -> no lsb_done; outputs 0; a new request is accepted after release.

Source files
------------

// File: rtl/viola_pkg.sv
// Shared definitions for the memory side: LSB/decoder opcodes, the "no op"
// marker and the mem_ctrl state encoding.
package viola_pkg;

  localparam logic [4:0] OP_LB   = 5'b10010;
  localparam logic [4:0] OP_LH   = 5'b10011;
  localparam logic [4:0] OP_LW   = 5'b10100;
  localparam logic [4:0] OP_LBU  = 5'b10101;
  localparam logic [4:0] OP_LHU  = 5'b10110;
  localparam logic [4:0] OP_SB   = 5'b10111;
  localparam logic [4:0] OP_SH   = 5'b11000;
  localparam logic [4:0] OP_SW   = 5'b11001;
  localparam logic [4:0] OP_NONE = 5'b11111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2
  } mem_state_e;

  // Bytes moved by an opcode; 0 marks an opcode the controller ignores.
  function automatic logic [2:0] op_bytes(input logic [4:0] op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return 3'd1;
      OP_LH, OP_LHU, OP_SH: return 3'd2;
      OP_LW, OP_SW:         return 3'd4;
      default:              return 3'd0;
    endcase
  endfunction

  function automatic logic op_is_store(input logic [4:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serialising RAM responder for the LSB and instruction-fetch queues.
// Optional IO write stall is enabled with `define MEM_CTRL_IO_STALL_EN.
module mem_ctrl
  import viola_pkg::*;
#(
  parameter int         ADDR_W    = 32,
  parameter logic [1:0] IO_REGION = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rollback,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_done,
  output logic [31:0]       if_data,
  input  logic              lsb_req,
  input  logic [4:0]        lsb_op,
  input  logic [ADDR_W-1:0] lsb_addr,
  input  logic [31:0]       lsb_wdata,
  input  logic [2:0]        lsb_rob,
  output logic              lsb_done,
  output logic [31:0]       lsb_rdata,
  output logic [2:0]        lsb_rob_out,
  output logic              busy,
`ifdef MEM_CTRL_IO_STALL_EN
  input  logic              io_buffer_full,
`endif
  input  logic [7:0]        mem_din,
  output logic [7:0]        mem_dout,
  output logic [ADDR_W-1:0] mem_a,
  output logic              mem_wr
);

  // Handshake: a requester holds req and operands until it sees its 1-cycle
  // done pulse; a request is only accepted while the controller is IDLE.
  mem_state_e        r_state;
  logic [ADDR_W-1:0] r_addr;
  logic [1:0]        r_idx;
  logic [1:0]        r_n_last;
  logic              r_tail;
  logic              r_is_if;
  logic              r_last_lsb;
  logic [4:0]        r_op;
  logic [2:0]        r_rob;
  logic [31:0]       r_sh;
  logic [ADDR_W-1:0] r_mem_a;
  logic [7:0]        r_mem_dout;
  logic              r_mem_wr;
  logic              r_if_done;
  logic [31:0]       r_if_data;
  logic              r_lsb_done;
  logic [31:0]       r_lsb_rdata;
  logic [2:0]        r_lsb_rob;

  logic [2:0]  w_lsb_n;
  logic [1:0]  w_lsb_last;
  logic        w_lsb_ok;
  logic        w_if_ok;
  logic        w_pick_if;
  logic        w_pick_lsb;
  logic        w_io_addr;
  logic        w_stall;
  logic [31:0] w_word;
  logic [31:0] w_aligned;

  function automatic logic [31:0] load_extend(input logic [4:0] op, input logic [31:0] w);
    case (op)
      OP_LB:   return {{24{w[7]}}, w[7:0]};
      OP_LH:   return {{16{w[15]}}, w[15:0]};
      OP_LBU:  return {24'h0, w[7:0]};
      OP_LHU:  return {16'h0, w[15:0]};
      default: return w;
    endcase
  endfunction

  assign w_lsb_n    = op_bytes(lsb_op);
  assign w_lsb_last = 2'(w_lsb_n - 3'd1);
  // A requester is masked in its own done cycle so the held request is not re-served.
  assign w_lsb_ok   = lsb_req && !r_lsb_done && (w_lsb_n != 3'd0);
  assign w_if_ok    = if_req && !r_if_done;
  assign w_pick_if  = w_if_ok && (!w_lsb_ok || r_last_lsb);
  assign w_pick_lsb = w_lsb_ok && !w_pick_if;

  assign w_io_addr = (r_addr[17:16] == IO_REGION);
`ifdef MEM_CTRL_IO_STALL_EN
  assign w_stall = (r_state == ST_WRITE) && io_buffer_full && w_io_addr;
`else
  assign w_stall = w_io_addr & 1'b0;
`endif

  // Load bytes enter at the top of the shift register; right-align by size.
  always_comb begin
    w_word    = {mem_din, r_sh[31:8]};
    w_aligned = w_word;
    case (r_n_last)
      2'd0:    w_aligned = {24'h0, w_word[31:24]};
      2'd1:    w_aligned = {16'h0, w_word[31:16]};
      default: w_aligned = w_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_idx       <= '0;
      r_n_last    <= '0;
      r_tail      <= 1'b0;
      r_is_if     <= 1'b0;
      r_last_lsb  <= 1'b0;
      r_op        <= OP_NONE;
      r_rob       <= '0;
      r_sh        <= '0;
      r_mem_a     <= '0;
      r_mem_dout  <= '0;
      r_mem_wr    <= 1'b0;
      r_if_done   <= 1'b0;
      r_if_data   <= '0;
      r_lsb_done  <= 1'b0;
      r_lsb_rdata <= '0;
      r_lsb_rob   <= '0;
    end else begin
      r_if_done  <= 1'b0;
      r_lsb_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_idx  <= '0;
          r_tail <= 1'b0;
          if (w_pick_if) begin
            r_state    <= ST_READ;
            r_is_if    <= 1'b1;
            r_last_lsb <= 1'b0;
            r_addr     <= if_addr;
            r_mem_a    <= if_addr;
            r_n_last   <= 2'd3;
            r_op       <= OP_NONE;
            r_mem_wr   <= 1'b0;
          end else if (w_pick_lsb) begin
            r_is_if    <= 1'b0;
            r_last_lsb <= 1'b1;
            r_addr     <= lsb_addr;
            r_mem_a    <= lsb_addr;
            r_n_last   <= w_lsb_last;
            r_op       <= lsb_op;
            r_rob      <= lsb_rob;
            if (op_is_store(lsb_op)) begin
              r_state    <= ST_WRITE;
              r_mem_wr   <= 1'b1;
              r_mem_dout <= lsb_wdata[7:0];
              r_sh       <= {8'h00, lsb_wdata[31:8]};
            end else begin
              r_state  <= ST_READ;
              r_mem_wr <= 1'b0;
            end
          end
        end
        ST_READ: begin
          // RAM data lags the address by one cycle: nothing to sample in cycle 1.
          if (r_idx != 2'd0 || r_tail)
            r_sh <= {mem_din, r_sh[31:8]};
          if (r_is_if && rollback) begin
            r_state <= ST_IDLE;
            r_mem_a <= '0;
          end else if (r_tail) begin
            r_state <= ST_IDLE;
            if (r_is_if) begin
              r_if_done <= 1'b1;
              r_if_data <= w_aligned;
            end else begin
              r_lsb_done  <= 1'b1;
              r_lsb_rdata <= load_extend(r_op, w_aligned);
              r_lsb_rob   <= r_rob;
            end
          end else if (r_idx == r_n_last) begin
            r_tail  <= 1'b1;
            r_mem_a <= '0;
          end else begin
            r_idx   <= r_idx + 2'd1;
            r_mem_a <= r_addr + ADDR_W'(r_idx) + ADDR_W'(1);
          end
        end
        ST_WRITE: begin
          if (!w_stall) begin
            if (r_idx == r_n_last) begin
              r_state     <= ST_IDLE;
              r_mem_a     <= '0;
              r_mem_wr    <= 1'b0;
              r_mem_dout  <= '0;
              r_lsb_done  <= 1'b1;
              r_lsb_rdata <= '0;
              r_lsb_rob   <= r_rob;
            end else begin
              r_idx      <= r_idx + 2'd1;
              r_mem_a    <= r_addr + ADDR_W'(r_idx) + ADDR_W'(1);
              r_mem_dout <= r_sh[7:0];
              r_sh       <= {8'h00, r_sh[31:8]};
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // A rollback landing on the fetch done cycle still suppresses the pulse.
  assign if_done     = r_if_done && !rollback;
  assign if_data     = r_if_data;
  assign lsb_done    = r_lsb_done;
  assign lsb_rdata   = r_lsb_rdata;
  assign lsb_rob_out = r_lsb_rob;
  assign busy        = (r_state != ST_IDLE);
  assign mem_a       = r_mem_a;
  assign mem_dout    = r_mem_dout;
  assign mem_wr      = r_mem_wr && !w_stall;

endmodule
